// File: rtl/alu_txn_sequencer.sv
// Request/response sequencer in front of the ALU: one operation outstanding,
// command-dependent result latency, response held under consumer backpressure.
module alu_txn_sequencer #(
    parameter int WIDTH     = 8,
    parameter int CMD_WIDTH = 4,
    parameter int LAT_NORM  = 2,
    parameter int LAT_MULT  = 3,
    parameter int CNT_W     = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [WIDTH-1:0]       req_opa,
    input  logic [WIDTH-1:0]       req_opb,
    input  logic [CMD_WIDTH-1:0]   req_cmd,
    input  logic                   req_mode,
    input  logic                   req_cin,
    input  logic [1:0]             req_inp_valid,
    output logic [WIDTH-1:0]       alu_opa,
    output logic [WIDTH-1:0]       alu_opb,
    output logic [CMD_WIDTH-1:0]   alu_cmd,
    output logic                   alu_ce,
    output logic                   alu_cin,
    output logic                   alu_mode,
    output logic [1:0]             alu_inp_valid,
    input  logic [2*WIDTH-1:0]     alu_res,
    input  logic [5:0]             alu_flags,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [2*WIDTH-1:0]     rsp_res,
    output logic [5:0]             rsp_flags,
    output logic [CNT_W-1:0]       txn_cnt,
    output logic                   busy
);
    localparam int WC_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t                 state_r;
    state_t                 state_s;
    logic [WC_W-1:0]        wait_cnt_r;
    logic [WC_W-1:0]        lat_sel_s;
    logic                   accept_s;
    logic                   rsp_fire_s;
    logic                   capture_s;
    logic                   is_mult_s;
    logic                   req_ready_s;
    logic                   busy_s;
    logic                   rsp_valid_s;
    logic                   alu_ce_s;

    logic                   req_ready_r;
    logic                   busy_r;
    logic                   rsp_valid_r;
    logic                   alu_ce_r;
    logic [WIDTH-1:0]       alu_opa_r;
    logic [WIDTH-1:0]       alu_opb_r;
    logic [CMD_WIDTH-1:0]   alu_cmd_r;
    logic                   alu_cin_r;
    logic                   alu_mode_r;
    logic [1:0]             alu_inp_valid_r;
    logic [2*WIDTH-1:0]     rsp_res_r;
    logic [5:0]             rsp_flags_r;
    logic [CNT_W-1:0]       txn_cnt_r;

    assign accept_s   = req_valid && req_ready_r;
    assign rsp_fire_s = rsp_valid_r && rsp_ready;
    // Latency is decided from the already-registered command, which is what the ALU sees.
    assign is_mult_s  = alu_mode_r && ((alu_cmd_r == CMD_WIDTH'(4'd9)) ||
                                       (alu_cmd_r == CMD_WIDTH'(4'd10)));
    assign lat_sel_s  = is_mult_s ? WC_W'(LAT_MULT) : WC_W'(LAT_NORM);
    assign capture_s  = (state_r == ST_WAIT) && (wait_cnt_r <= 8'd1);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_r <= ST_IDLE;
        else     state_r <= state_s;
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE:  if (accept_s)   state_s = ST_ISSUE; else state_s = ST_IDLE;
            ST_ISSUE: state_s = ST_WAIT;
            ST_WAIT:  if (capture_s)  state_s = ST_RESP;  else state_s = ST_WAIT;
            ST_RESP:  if (rsp_fire_s) state_s = ST_IDLE;  else state_s = ST_RESP;
            default:  state_s = ST_IDLE;
        endcase
    end

    // Output decode from the upcoming state so the flags are registered yet cycle-aligned
    always_comb begin
        req_ready_s = 1'b0;
        busy_s      = 1'b1;
        rsp_valid_s = 1'b0;
        alu_ce_s    = 1'b0;
        case (state_s)
            ST_IDLE:  begin req_ready_s = 1'b1; busy_s = 1'b0; end
            ST_ISSUE: alu_ce_s    = 1'b1;
            ST_WAIT:  busy_s      = 1'b1;
            ST_RESP:  rsp_valid_s = 1'b1;
            default:  busy_s      = 1'b1;
        endcase
    end

    // Control output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_ready_r <= 1'b0;
            busy_r      <= 1'b0;
            rsp_valid_r <= 1'b0;
            alu_ce_r    <= 1'b0;
        end else begin
            req_ready_r <= req_ready_s;
            busy_r      <= busy_s;
            rsp_valid_r <= rsp_valid_s;
            alu_ce_r    <= alu_ce_s;
        end
    end

    // ALU operand registers: loaded on accept, held through the wait, cleared at capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_opa_r       <= '0;
            alu_opb_r       <= '0;
            alu_cmd_r       <= '0;
            alu_cin_r       <= 1'b0;
            alu_mode_r      <= 1'b0;
            alu_inp_valid_r <= 2'b00;
        end else if (accept_s) begin
            alu_opa_r       <= req_opa;
            alu_opb_r       <= req_opb;
            alu_cmd_r       <= req_cmd;
            alu_cin_r       <= req_cin;
            alu_mode_r      <= req_mode;
            alu_inp_valid_r <= req_inp_valid;
        end else if (capture_s) begin
            alu_opa_r       <= '0;
            alu_opb_r       <= '0;
            alu_cmd_r       <= '0;
            alu_cin_r       <= 1'b0;
            alu_mode_r      <= 1'b0;
            alu_inp_valid_r <= 2'b00;
        end
    end

    // Latency countdown: loaded during issue, RES sampled when it reaches one
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                     wait_cnt_r <= 8'd0;
        else if (state_r == ST_ISSUE)                wait_cnt_r <= lat_sel_s;
        else if ((state_r == ST_WAIT) && !capture_s) wait_cnt_r <= wait_cnt_r - 8'd1;
    end

    // Response capture and completed-transaction counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_res_r   <= '0;
            rsp_flags_r <= 6'd0;
            txn_cnt_r   <= '0;
        end else begin
            if (capture_s) begin
                rsp_res_r   <= alu_res;
                rsp_flags_r <= alu_flags;
            end
            if (rsp_fire_s) txn_cnt_r <= txn_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign req_ready     = req_ready_r;
    assign busy          = busy_r;
    assign rsp_valid     = rsp_valid_r;
    assign alu_ce        = alu_ce_r;
    assign alu_opa       = alu_opa_r;
    assign alu_opb       = alu_opb_r;
    assign alu_cmd       = alu_cmd_r;
    assign alu_cin       = alu_cin_r;
    assign alu_mode      = alu_mode_r;
    assign alu_inp_valid = alu_inp_valid_r;
    assign rsp_res       = rsp_res_r;
    assign rsp_flags     = rsp_flags_r;
    assign txn_cnt       = txn_cnt_r;

endmodule

// File: tb/tb_alu_txn_sequencer.sv
// Bench for alu_txn_sequencer: an arithmetic ALU stand-in that presents RES only
// in the cycle it is due, directed scenarios, then randomized transactions.
module tb_alu_txn_sequencer;
    localparam int W = 8, CW = 4, LN = 2, LM = 3, CNW = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic            req_valid, req_ready;
    logic [W-1:0]    req_opa, req_opb;
    logic [CW-1:0]   req_cmd;
    logic            req_mode, req_cin;
    logic [1:0]      req_inp_valid;
    logic [W-1:0]    alu_opa, alu_opb;
    logic [CW-1:0]   alu_cmd;
    logic            alu_ce, alu_cin, alu_mode;
    logic [1:0]      alu_inp_valid;
    logic [2*W-1:0]  alu_res;
    logic [5:0]      alu_flags;
    logic            rsp_valid, rsp_ready;
    logic [2*W-1:0]  rsp_res;
    logic [5:0]      rsp_flags;
    logic [CNW-1:0]  txn_cnt;
    logic            busy;

    int              total = 0;
    int              bad = 0;
    int              cyc = 0;
    int              due = -1;
    logic [2*W-1:0]  pend_res = '0;
    logic [5:0]      pend_flags = '0;
    logic [CNW-1:0]  exp_cnt = '0;

    always #5 clk = ~clk;

    alu_txn_sequencer #(.WIDTH(W), .CMD_WIDTH(CW), .LAT_NORM(LN), .LAT_MULT(LM), .CNT_W(CNW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_opa(req_opa), .req_opb(req_opb), .req_cmd(req_cmd),
        .req_mode(req_mode), .req_cin(req_cin), .req_inp_valid(req_inp_valid),
        .alu_opa(alu_opa), .alu_opb(alu_opb), .alu_cmd(alu_cmd),
        .alu_ce(alu_ce), .alu_cin(alu_cin), .alu_mode(alu_mode), .alu_inp_valid(alu_inp_valid),
        .alu_res(alu_res), .alu_flags(alu_flags),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_res(rsp_res), .rsp_flags(rsp_flags),
        .txn_cnt(txn_cnt), .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference ALU, flags ordered {ERR,OFLOW,COUT,E,G,L}
    function automatic void alu_ref(input logic [7:0] a, input logic [7:0] b, input logic [3:0] cmd,
                                    input logic mode, input logic cin,
                                    output logic [15:0] res, output logic [5:0] fl);
        int s;
        res = 16'd0;
        fl  = 6'd0;
        if (mode) begin
            case (cmd)
                4'd0:  begin s = int'(a) + int'(b); res = 16'(s); fl[3] = (s > 255); end
                4'd1:  begin s = int'(a) - int'(b); res = {8'd0, 8'(s)}; fl[4] = (s < 0); end
                4'd2:  begin s = int'(a) + int'(b) + int'(cin); res = 16'(s); fl[3] = (s > 255); end
                4'd8:  fl[2:0] = (a == b) ? 3'b100 : ((a > b) ? 3'b010 : 3'b001);
                4'd9:  res = 16'((int'(a) + 1) * (int'(b) + 1));
                4'd10: res = 16'((int'(a) * 2 % 256) * int'(b));
                default: fl[5] = 1'b1;
            endcase
        end else begin
            case (cmd)
                4'd0:  res = {8'd0, a & b};
                4'd1:  res = {8'd0, a | b};
                4'd2:  res = {8'd0, a ^ b};
                default: fl[5] = 1'b1;
            endcase
        end
    endfunction

    function automatic int exp_lat(input logic mode, input logic [3:0] cmd);
        return (mode && (cmd == 4'd9 || cmd == 4'd10)) ? LM : LN;
    endfunction

    // One cycle: move to the next negedge and drive the ALU stand-in
    task automatic step();
        @(negedge clk);
        cyc++;
        if (rst) due = -1;
        else if (alu_ce) begin
            alu_ref(alu_opa, alu_opb, alu_cmd, alu_mode, alu_cin, pend_res, pend_flags);
            due = cyc + exp_lat(alu_mode, alu_cmd);
        end
        if (cyc == due) begin
            alu_res = pend_res;
            alu_flags = pend_flags;
        end else begin
            alu_res = 16'($urandom);
            alu_flags = 6'($urandom);
            if (alu_res == pend_res) alu_res = ~alu_res;
        end
    endtask

    task automatic do_txn(input logic [7:0] a, input logic [7:0] b, input logic [3:0] cmd,
                          input logic mode, input logic cin, input logic [1:0] iv,
                          input int stall, input logic poke,
                          output int acc_cyc, output logic [15:0] got_res, output logic [5:0] got_fl);
        logic [15:0] er;
        logic [5:0]  ef;
        int          lat;
        int          n;
        alu_ref(a, b, cmd, mode, cin, er, ef);
        lat = exp_lat(mode, cmd);
        req_opa = a; req_opb = b; req_cmd = cmd; req_mode = mode; req_cin = cin;
        req_inp_valid = iv; req_valid = 1'b1;
        n = 0;
        while (req_ready !== 1'b1 && n < 50) begin step(); n++; end
        chk("accept_wait", 32'(n < 50), 32'd1);
        acc_cyc = cyc;
        step();
        req_valid = poke;
        req_opa = ~a;
        chk("issue_ce", alu_ce, 1'b1);
        chk("issue_opa", alu_opa, a);
        chk("issue_opb", alu_opb, b);
        chk("issue_cmd", alu_cmd, cmd);
        chk("issue_mode", alu_mode, mode);
        chk("issue_cin", alu_cin, cin);
        chk("issue_iv", alu_inp_valid, iv);
        chk("issue_busy", busy, 1'b1);
        chk("issue_ready", req_ready, 1'b0);
        for (int k = 0; k < lat; k++) begin
            step();
            chk("wait_ce", alu_ce, 1'b0);
            chk("wait_cmd", alu_cmd, cmd);
            chk("wait_mode", alu_mode, mode);
            chk("wait_opa", alu_opa, a);
            chk("wait_rsp", rsp_valid, 1'b0);
        end
        rsp_ready = (stall == 0);
        step();
        chk("rsp_valid", rsp_valid, 1'b1);
        chk("rsp_res", rsp_res, er);
        chk("rsp_flags", rsp_flags, ef);
        chk("rsp_ce", alu_ce, 1'b0);
        got_res = rsp_res;
        got_fl = rsp_flags;
        for (int k = 0; k < stall; k++) begin
            step();
            chk("hold_valid", rsp_valid, 1'b1);
            chk("hold_res", rsp_res, er);
            chk("hold_flags", rsp_flags, ef);
            chk("hold_ready", req_ready, 1'b0);
            if (k == stall - 1) rsp_ready = 1'b1;
        end
        req_valid = 1'b0;
        step();
        rsp_ready = 1'b0;
        exp_cnt = exp_cnt + 16'd1;
        chk("idle_rsp", rsp_valid, 1'b0);
        chk("idle_cnt", txn_cnt, exp_cnt);
        chk("idle_ready", req_ready, 1'b1);
        chk("idle_busy", busy, 1'b0);
        chk("idle_cmd", alu_cmd, 4'd0);
        chk("idle_opa", alu_opa, 8'd0);
    endtask

    initial begin
        int          acc1, acc2;
        logic [15:0] r;
        logic [5:0]  f;
        rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
        req_opa = '0; req_opb = '0; req_cmd = '0; req_mode = 1'b0; req_cin = 1'b0;
        req_inp_valid = 2'b00; alu_res = '0; alu_flags = '0;
        step(); step();
        chk("rst_ready", req_ready, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_rsp", rsp_valid, 1'b0);
        chk("rst_cnt", txn_cnt, 16'd0);
        chk("rst_ce", alu_ce, 1'b0);
        chk("rst_res", rsp_res, 16'd0);
        rst = 1'b0;
        step(); step();
        chk("post_rst_ready", req_ready, 1'b1);

        // ADD 200+100
        do_txn(8'd200, 8'd100, 4'd0, 1'b1, 1'b0, 2'b11, 0, 1'b0, acc1, r, f);
        chk("add_res", r, 16'd300);
        chk("add_flags", f, 6'b001000);
        // Multiply (3+1)*(4+1)
        do_txn(8'd3, 8'd4, 4'd9, 1'b1, 1'b0, 2'b11, 0, 1'b0, acc1, r, f);
        chk("mul_res", r, 16'd20);
        // AND under 5 cycles of backpressure with a competing request
        do_txn(8'hF0, 8'h3C, 4'd0, 1'b0, 1'b0, 2'b11, 5, 1'b1, acc1, r, f);
        chk("and_res", r, 16'h0030);
        chk("and_cnt", txn_cnt, 16'd3);
        // Back-to-back compares
        exp_cnt = 16'd0;
        rst = 1'b1; step(); rst = 1'b0; step(); step();
        do_txn(8'd5, 8'd5, 4'd8, 1'b1, 1'b0, 2'b11, 0, 1'b0, acc1, r, f);
        chk("cmp_eq", f, 6'b000100);
        do_txn(8'd7, 8'd2, 4'd8, 1'b1, 1'b0, 2'b11, 0, 1'b0, acc2, r, f);
        chk("cmp_gt", f, 6'b000010);
        chk("cmp_cnt", txn_cnt, 16'd2);
        chk("spacing", 32'(acc2 - acc1), 32'(LN + 3));

        // Reset during WAIT of a SUB
        req_opa = 8'd9; req_opb = 8'd4; req_cmd = 4'd1; req_mode = 1'b1; req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        step();
        chk("sub_busy", busy, 1'b1);
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_cnt", txn_cnt, 16'd0);
        chk("mid_rst_cmd", alu_cmd, 4'd0);
        step(); step();
        rst = 1'b0;
        exp_cnt = 16'd0;
        for (int k = 0; k < 6; k++) begin
            step();
            chk("no_rsp_after_rst", rsp_valid, 1'b0);
        end
        chk("cnt_after_rst", txn_cnt, 16'd0);
        do_txn(8'd1, 8'd1, 4'd0, 1'b1, 1'b0, 2'b11, 0, 1'b0, acc1, r, f);
        chk("add11_res", r, 16'd2);

        // Randomized transactions
        for (int i = 0; i < 24; i++) begin
            do_txn(8'($urandom), 8'($urandom), 4'($urandom_range(0, 15)), 1'($urandom),
                   1'($urandom), 2'($urandom), $urandom_range(0, 3), 1'($urandom), acc1, r, f);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
